// File: rtl/data_bus_arbiter_if.sv
// Shared data-bus arbitration interface: source requests/locks/data in, grant and muxed bus out.
// master = bus sources side, slave = arbiter side.
interface data_bus_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 16
);
   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ-1:0]            lock;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            grant;
   logic                          grant_valid;
   logic [OW-1:0]                 owner_id;
   logic [DATA_WIDTH-1:0]         bus_data;
   logic                          preempt;
   logic [1:0]                    arb_state_output;

   modport master (
      output req, lock, req_data,
      input  grant, grant_valid, owner_id, bus_data, preempt, arb_state_output
   );

   modport slave (
      input  req, lock, req_data,
      output grant, grant_valid, owner_id, bus_data, preempt, arb_state_output
   );
endinterface

// File: rtl/data_bus_arbiter.sv
// Round-robin owner arbiter and mux for the shared data bus; request-to-grant 1 cycle, one idle turnaround between owners.
// Ownership is bounded by MAX_HOLD unless the owner locks; non-owner req/lock/data never affect the bus.
module data_bus_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REQ    = 4,
   parameter int MAX_HOLD   = 8
) (
   input  logic                clk,
   input  logic                reset,
   data_bus_arbiter_if.slave   bus
);
   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_TURN  = 2'd2;

   logic [1:0]            state;
   logic [OW-1:0]         rr_ptr;
   logic [7:0]            hold_cnt;
   logic [NUM_REQ-1:0]    grant_q;
   logic [OW-1:0]         owner_q;
   logic                  preempt_q;

   logic [OW-1:0]         win;
   logic [OW-1:0]         next_ptr;
   logic [NUM_REQ-1:0]    win_onehot;
   logic [OW:0]           scan_sum;
   logic [OW-1:0]         scan_idx;
   logic                  found;
   logic [DATA_WIDTH-1:0] bus_data_c;

   // First requester at or above rr_ptr, wrapping; sum is one bit wider so non-power-of-two NUM_REQ wraps correctly.
   always_comb begin
      win      = '0;
      found    = 1'b0;
      scan_sum = '0;
      scan_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_sum = {1'b0, rr_ptr} + (OW+1)'(k);
         if (scan_sum >= (OW+1)'(NUM_REQ))
            scan_sum = scan_sum - (OW+1)'(NUM_REQ);
         scan_idx = scan_sum[OW-1:0];
         if (!found && bus.req[scan_idx]) begin
            found = 1'b1;
            win   = scan_idx;
         end
      end
   end

   always_comb begin
      win_onehot      = '0;
      win_onehot[win] = 1'b1;
   end

   assign next_ptr = (win == OW'(NUM_REQ-1)) ? '0 : win + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         hold_cnt  <= '0;
         grant_q   <= '0;
         owner_q   <= '0;
         preempt_q <= 1'b0;
      end else begin
         preempt_q <= 1'b0;
         case (state)
            ST_GRANT: begin
               // Voluntary release wins over timeout so a coincident drop is never flagged as preemption.
               if (!bus.req[owner_q]) begin
                  state   <= ST_TURN;
                  grant_q <= '0;
               end else if (hold_cnt == 8'(MAX_HOLD) && !bus.lock[owner_q]) begin
                  state     <= ST_TURN;
                  grant_q   <= '0;
                  preempt_q <= 1'b1;
               end else if (hold_cnt != 8'(MAX_HOLD)) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: begin
               if (|bus.req) begin
                  state    <= ST_GRANT;
                  grant_q  <= win_onehot;
                  owner_q  <= win;
                  hold_cnt <= 8'd1;
                  rr_ptr   <= next_ptr;
               end else begin
                  state   <= ST_IDLE;
                  grant_q <= '0;
               end
            end
         endcase
      end
   end

   // AND-OR mux off the registered grant: all-zero grant yields a zero bus.
   always_comb begin
      bus_data_c = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i])
            bus_data_c = bus_data_c | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign bus.grant            = grant_q;
   assign bus.grant_valid      = |grant_q;
   assign bus.owner_id         = owner_q;
   assign bus.bus_data         = bus_data_c;
   assign bus.preempt          = preempt_q;
   assign bus.arb_state_output = state;
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: per-cycle expected outputs from a behavioural model are queued
// by the stimulus process and compared by an independent monitor on the falling edge.
module tb_data_bus_arbiter;
   localparam int N  = 4;
   localparam int DW = 16;
   localparam int MH = 8;

   logic clk;
   logic reset;

   data_bus_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

   data_bus_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MAX_HOLD(MH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0]  g;
      logic          gv;
      logic [1:0]    id;
      logic [DW-1:0] bd;
      logic          pre;
      logic [1:0]    st;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Reference model: owner (-1 = nobody), cycles owned so far, round-robin start point,
   // and whether the current cycle is the mandatory gap after a release.
   int   m_owner, m_held, m_ptr, m_last;
   bit   m_gap, m_pre;
   logic [N-1:0] p_req, p_lock;

   task automatic model_reset();
      m_owner = -1; m_held = 0; m_ptr = 0; m_last = 0; m_gap = 0; m_pre = 0;
   endtask

   task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l);
      m_pre = 0;
      if (m_owner >= 0) begin
         if (!r[m_owner]) begin
            m_owner = -1; m_gap = 1;
         end else if (m_held >= MH && !l[m_owner]) begin
            m_owner = -1; m_gap = 1; m_pre = 1;
         end else begin
            m_held++;
         end
      end else begin
         m_gap = 0;
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (m_owner < 0 && r[c]) m_owner = c;
         end
         if (m_owner >= 0) begin
            m_held = 1;
            m_ptr  = (m_owner + 1) % N;
            m_last = m_owner;
         end
      end
   endtask

   function automatic logic [N*DW-1:0] rd();
      return {$urandom, $urandom};
   endfunction

   task automatic tick(input logic [N-1:0] r, input logic [N-1:0] l, input logic rst,
                       input logic [N*DW-1:0] d);
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (!reset) model_reset();
      else        model_step(p_req, p_lock);
      reset = rst;
      if (!rst) model_reset();
      bus.req      = r;
      bus.lock     = l;
      bus.req_data = d;
      p_req  = r;
      p_lock = l;
      e.g   = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      e.gv  = (m_owner >= 0);
      e.id  = 2'(m_last);
      e.bd  = (m_owner >= 0) ? d[m_owner*DW +: DW] : '0;
      e.pre = m_pre;
      e.st  = (m_owner >= 0) ? 2'd1 : (m_gap ? 2'd2 : 2'd0);
      exp_q.push_back(e);
   endtask

   // Monitor: compares whatever the DUT presents against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.grant !== e.g || bus.grant_valid !== e.gv || bus.owner_id !== e.id ||
                bus.bus_data !== e.bd || bus.preempt !== e.pre || bus.arb_state_output !== e.st) begin
               errors++;
               $display("FAIL outputs cyc=%0d got g=%b gv=%b id=%0d bus=%h pre=%b st=%0d want g=%b gv=%b id=%0d bus=%h pre=%b st=%0d",
                        cyc, bus.grant, bus.grant_valid, bus.owner_id, bus.bus_data, bus.preempt,
                        bus.arb_state_output, e.g, e.gv, e.id, e.bd, e.pre, e.st);
            end
         end
      end
   end

   initial begin
      logic [N-1:0]    r, l;
      logic [N*DW-1:0] d;
      reset        = 1'b0;
      bus.req      = '0;
      bus.lock     = '0;
      bus.req_data = '0;
      p_req  = '0;
      p_lock = '0;
      model_reset();

      // Reset, then a single request from source 1 carrying BEEF, then release.
      tick(4'b0000, 4'b0000, 1'b0, rd());
      tick(4'b0000, 4'b0000, 1'b1, rd());
      tick(4'b0000, 4'b0000, 1'b1, rd());
      for (int i = 0; i < 3; i++) begin
         d = rd();
         d[1*DW +: DW] = 16'hBEEF;
         tick(4'b0010, 4'b0000, 1'b1, d);
      end
      for (int i = 0; i < 3; i++) tick(4'b0000, 4'b0000, 1'b1, rd());

      // Fairness: all request, owner drops after two granted cycles and reasserts in the gap.
      for (int i = 0; i < 16; i++) begin
         r = 4'b1111;
         if (m_owner >= 0 && m_held >= 2) r[m_owner] = 1'b0;
         tick(r, 4'b0000, 1'b1, rd());
      end
      for (int i = 0; i < 3; i++) tick(4'b0000, 4'b0000, 1'b1, rd());

      // Timeout: source 0 requests forever, source 2 waits.
      for (int i = 0; i < 24; i++) tick(4'b0101, 4'b0000, 1'b1, rd());
      for (int i = 0; i < 3; i++) tick(4'b0000, 4'b0000, 1'b1, rd());

      // Lock override by owner 3, with a non-owner lock that must be ignored.
      for (int i = 0; i < 20 && m_owner != 3; i++) tick(4'b1000, 4'b0010, 1'b1, rd());
      for (int i = 0; i < 20; i++) tick(4'b1111, 4'b1010, 1'b1, rd());
      for (int i = 0; i < 6; i++)  tick(4'b1111, 4'b0010, 1'b1, rd());
      for (int i = 0; i < 3; i++)  tick(4'b0000, 4'b0000, 1'b1, rd());

      // Owner drops its request exactly when its hold count reaches the limit.
      for (int i = 0; i < 20; i++) begin
         r = 4'b0001;
         if (m_owner == 0 && m_held >= MH) r = 4'b0000;
         tick(r, 4'b0000, 1'b1, rd());
      end

      // Asynchronous reset while source 2 owns the bus.
      for (int i = 0; i < 20 && m_owner != 2; i++) tick(4'b0100, 4'b0000, 1'b1, rd());
      tick(4'b0110, 4'b0000, 1'b0, rd());
      tick(4'b0110, 4'b0000, 1'b0, rd());
      for (int i = 0; i < 4; i++) tick(4'b0110, 4'b0000, 1'b1, rd());

      // Random traffic with sticky requests, occasional locks and rare resets.
      r = '0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         l = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         tick(r, l, ($urandom_range(0, 299) != 0), rd());
      end

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
